// File: rtl/trigger_gen_multi.sv
// Multi-channel programmable trigger generator: per-channel modulo-period counters with registered pulses.
// Build option: define TRIG_GEN_LEVEL_EN to turn each trigger into a toggling level (square wave of period 2P).
module trigger_gen_multi #(
    parameter int WIDTH          = 8,
    parameter int CHANNELS       = 4,
    parameter int DEFAULT_PERIOD = 2,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic                cfg_oneshot,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] stop,
    input  logic [CHANNELS-1:0] nul,
    output logic [CHANNELS-1:0] trigger,
    output logic [CHANNELS-1:0] busy,
    output logic                cfg_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

`ifdef TRIG_GEN_LEVEL_EN
    localparam logic LEVEL_MODE = 1'b1;
`else
    localparam logic LEVEL_MODE = 1'b0;
`endif

    localparam logic [CH_W:0]    CH_LIM    = (CH_W + 1)'(CHANNELS);
    localparam logic [WIDTH-1:0] PERIOD_RV = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    logic cfg_ok_s;
    logic cfg_err_r;

    assign cfg_ok_s = cfg_we && (cfg_period != '0) && ({1'b0, cfg_ch} < CH_LIM);
    assign cfg_err  = cfg_err_r;

    // Rejected-write flag, one cycle wide and one cycle late.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_we && !cfg_ok_s;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           state_r;
        logic [WIDTH-1:0] cnt_r;
        logic [WIDTH-1:0] period_r;
        logic [WIDTH-1:0] last_s;
        logic             oneshot_r;
        logic             trig_r;
        logic             busy_r;
        logic             fin_s;
        logic             hit_s;

        // >= rather than == so a period shrunk below the live count still terminates.
        assign last_s  = period_r - ONE_W;
        assign fin_s   = (state_r == RUN) && (cnt_r >= last_s);
        assign hit_s   = cfg_ok_s && (cfg_ch == CH_W'(g));
        assign trigger[g] = trig_r;
        assign busy[g]    = busy_r;

        // Per-channel configuration; a running channel sees the new period on the next compare.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                period_r  <= PERIOD_RV;
                oneshot_r <= 1'b0;
            end else if (hit_s) begin
                period_r  <= cfg_period;
                oneshot_r <= cfg_oneshot;
            end else begin
                period_r  <= period_r;
                oneshot_r <= oneshot_r;
            end
        end

        // Channel FSM: counter, state, busy and trigger register.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_r <= IDLE;
                cnt_r   <= '0;
                trig_r  <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        cnt_r <= '0;
                        if (start[g] && !stop[g]) begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                            trig_r  <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            // A level left high by a one-shot finish holds until stop/start/reset.
                            trig_r  <= LEVEL_MODE ? (trig_r && !stop[g]) : 1'b0;
                        end
                    end
                    RUN: begin
                        if (stop[g]) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            cnt_r   <= '0;
                            trig_r  <= 1'b0;
                        end else if (start[g]) begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                            cnt_r   <= '0;
                            trig_r  <= LEVEL_MODE ? 1'b0 : fin_s;
                        end else if (nul[g]) begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                            cnt_r   <= '0;
                            trig_r  <= LEVEL_MODE ? (trig_r ^ fin_s) : fin_s;
                        end else if (fin_s) begin
                            cnt_r  <= '0;
                            trig_r <= LEVEL_MODE ? !trig_r : 1'b1;
                            if (oneshot_r) begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end else begin
                                state_r <= RUN;
                                busy_r  <= 1'b1;
                            end
                        end else begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                            cnt_r   <= cnt_r + ONE_W;
                            trig_r  <= LEVEL_MODE ? trig_r : 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= '0;
                        trig_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
